snn_input_sequencer: RTL and testbench

- Sequences readout of the 784-pixel binary input image after the UART input loader reports the image is complete (its `ready` level).
- Walks addresses 0..NUM_PIX-1 on the loader's read port, captures each 1-bit pixel and presents it downstream as a valid/ready pixel stream to the hidden-layer engine.
- Counts set pixels, signals completion, then pulses a re-arm so the loader can accept the next image.
- Sits between `load_input_file` and the first SNN layer controller.

---
 rtl/snn_pkg.sv | 14 +
 rtl/snn_input_sequencer.sv | 170 +++++++++++++++++
 tb/tb_snn_input_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared constants and the input-sequencer state encoding for the SNN input path.
package snn_pkg;
  localparam int NUM_PIX    = 784;
  localparam int IMG_BYTES  = 98;
  localparam int PIX_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    FINISH
  } seq_state_t;
endpackage

// File: rtl/snn_input_sequencer.sv
// Walks the loader's pixel read port once per stored image and streams each pixel
// downstream, counting set pixels and re-arming the loader when the scan completes.
module snn_input_sequencer
  import snn_pkg::*;
#(
  parameter int NUM_PIX = snn_pkg::NUM_PIX,
  parameter int ADDR_W  = snn_pkg::PIX_ADDR_W,
  parameter int RD_LAT  = 1,
  parameter int CNT_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              img_ready,
  input  logic              q,
  output logic [ADDR_W-1:0] addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  spike_cnt,
  output logic              rearm,
  output logic              abort,
  output seq_state_t        dbg_state
);

  // out_valid/out_ready: a beat transfers on a clock edge where both are high; while
  // out_valid is high the beat fields are held stable, and out_ready is ignored otherwise.

  localparam int                WAIT_W    = 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
  localparam logic [CNT_W-1:0]  SPIKE_MAX = {CNT_W{1'b1}};

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              out_valid_q, out_valid_d;
  logic              out_bit_q, out_bit_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic [CNT_W-1:0]  spike_q, spike_d;
  logic              img_ready_q;
  logic              armed_q, armed_d;
  logic              scanning;

  assign scanning = (state_q == ISSUE) || (state_q == WAIT) || (state_q == EMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wait_q      <= '0;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_idx_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      spike_q     <= '0;
      img_ready_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wait_q      <= wait_d;
      out_valid_q <= out_valid_d;
      out_bit_q   <= out_bit_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      spike_q     <= spike_d;
      img_ready_q <= img_ready;
      armed_q     <= armed_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wait_d      = wait_q;
    out_valid_d = out_valid_q;
    out_bit_d   = out_bit_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    spike_d     = spike_q;
    // A new scan needs img_ready to have been low since the last start.
    armed_d     = armed_q | ~img_ready;

    unique case (state_q)
      IDLE: begin
        if (img_ready_q && armed_q) begin
          spike_d = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          armed_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wait_d  = WAIT_W'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) begin
          out_bit_d   = q;
          out_idx_d   = addr_q;
          out_last_d  = (addr_q == LAST_ADDR);
          out_valid_d = 1'b1;
          if (q && (spike_q != SPIKE_MAX)) spike_d = spike_q + CNT_W'(1);
          state_d = EMIT;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ISSUE;
          end
        end
      end
      FINISH: begin
        addr_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Losing img_ready mid-scan wins over any acceptance in the same cycle.
    if (scanning && !img_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      addr_d      = '0;
      spike_d     = spike_q;
      done_d      = 1'b0;
      abort_d     = 1'b1;
    end
  end

  assign addr      = addr_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rearm     = done_q;
  assign abort     = abort_q;
  assign spike_cnt = spike_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_snn_input_sequencer.sv
// Directed bench: two sequencers (read latency 1 and 3) share stimulus and a modelled
// loader read port; every observation is checked against hand-derived values.
module tb_snn_input_sequencer;
  import snn_pkg::*;

  localparam int NPIX = 784;

  logic       clk = 1'b0;
  logic       rst, img_ready, out_ready;
  logic       mem [0:NPIX-1];
  logic [0:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;

  logic       q, out_valid, out_bit, out_last, busy, done, rearm, abort;
  logic [9:0] addr, out_idx, spike_cnt;
  seq_state_t dbg_state;

  logic       q3, out_valid3, out_bit3, out_last3, busy3, done3, rearm3, abort3;
  logic [9:0] addr3, out_idx3, spike_cnt3;
  seq_state_t dbg_state3;
  logic       p1, p2;

  always #5 clk = ~clk;

  always_ff @(posedge clk) q <= mem[addr];

  always_ff @(posedge clk) begin
    p1 <= mem[addr3];
    p2 <= p1;
    q3 <= p2;
  end

  snn_input_sequencer #(.NUM_PIX(NPIX), .ADDR_W(10), .RD_LAT(1), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .img_ready(img_ready), .q(q), .addr(addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .done(done), .spike_cnt(spike_cnt),
    .rearm(rearm), .abort(abort), .dbg_state(dbg_state)
  );

  snn_input_sequencer #(.NUM_PIX(NPIX), .ADDR_W(10), .RD_LAT(3), .CNT_W(10)) dut3 (
    .clk(clk), .rst(rst), .img_ready(img_ready), .q(q3), .addr(addr3),
    .out_valid(out_valid3), .out_ready(out_ready), .out_bit(out_bit3), .out_idx(out_idx3),
    .out_last(out_last3), .busy(busy3), .done(done3), .spike_cnt(spike_cnt3),
    .rearm(rearm3), .abort(abort3), .dbg_state(dbg_state3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] b);
    exp_q.delete();
    for (int n = 0; n < NPIX; n++) begin
      mem[n] = b[n % 8];
      exp_q.push_back(b[n % 8]);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_addr", 32'(addr), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_bit", 32'(out_bit), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_spike_cnt", 32'(spike_cnt), 0);
    chk("rst_rearm", 32'(rearm), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
  endtask

  // Runs one full scan on the RD_LAT=1 instance; stalls 20 edges at index bp_idx.
  task automatic run_scan(input int bp_idx, input int exp_ones);
    int beats, dones, rearms, stall;
    logic [0:0] exp_b;
    beats = 0; dones = 0; rearms = 0; stall = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8000 && dones == 0; cyc++) begin
      tick();
      if (done) dones++;
      if (rearm) rearms++;
      if (done || rearm) begin
        chk("done_with_rearm", 32'(rearm), 32'(done));
        chk("done_busy_low", 32'(busy), 0);
      end
      if (out_valid && int'(out_idx) == bp_idx && stall == 0) begin
        stall = 1;
        out_ready = 1'b0;
      end else if (stall > 0 && stall < 20) begin
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_idx", 32'(out_idx), 32'(bp_idx));
        chk("bp_addr", 32'(addr), 32'(bp_idx));
        chk("bp_bit", 32'(out_bit), 32'(exp_q[0]));
        stall++;
      end else if (out_valid) begin
        out_ready = 1'b1;
        exp_b = (exp_q.size() == 0) ? 1'bx : exp_q.pop_front();
        chk("beat_idx", 32'(out_idx), 32'(beats));
        chk("beat_bit", 32'(out_bit), 32'(exp_b));
        chk("beat_last", 32'(out_last), (beats == NPIX - 1) ? 1 : 0);
        beats++;
      end
    end
    out_ready = 1'b1;
    chk("scan_beats", 32'(beats), 784);
    chk("scan_dones", 32'(dones), 1);
    chk("scan_rearms", 32'(rearms), 1);
    chk("scan_spike_cnt", 32'(spike_cnt), 32'(exp_ones));
    chk("scan_exp_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first1, second1, first3, second3, found, bad;

    rst = 1'b1; img_ready = 1'b0; out_ready = 1'b1;
    fill(8'h00);
    tick(); tick(); tick();
    chk_reset_vals();
    rst = 1'b0;
    tick(); tick();
    chk("idle_state", 32'(dbg_state), 32'(IDLE));

    // Latency and beat period for read latency 1 and 3.
    fill(8'hFF);
    img_ready = 1'b1;
    tick();
    first1 = 0; second1 = 0; first3 = 0; second3 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid) begin
        if (first1 == 0) first1 = k;
        else if (second1 == 0) second1 = k;
      end
      if (out_valid3) begin
        if (first3 == 0) first3 = k;
        else if (second3 == 0) second3 = k;
      end
    end
    chk("latency_rd1", 32'(first1), 3);
    chk("period_rd1", 32'(second1 - first1), 3);
    chk("latency_rd3", 32'(first3), 5);
    chk("period_rd3", 32'(second3 - first3), 5);
    img_ready = 1'b0;
    tick(); tick(); tick();

    // Full scan of all-ones, then a held-high img_ready must not restart.
    fill(8'hFF);
    img_ready = 1'b1;
    run_scan(-1, 784);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("hold_no_restart", 32'(busy), 0);
    end
    chk("hold_spike_cnt", 32'(spike_cnt), 784);
    chk("hold_addr", 32'(addr), 0);

    // 0xA5 pattern with a 20-edge stall at index 100.
    img_ready = 1'b0;
    tick(); tick();
    fill(8'hA5);
    img_ready = 1'b1;
    run_scan(100, 392);

    // Abort at index 300 in the same cycle as an acceptance.
    img_ready = 1'b0;
    tick(); tick();
    fill(8'hA5);
    img_ready = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 3000 && found == 0; cyc++) begin
      tick();
      if (out_valid && out_idx == 10'd300) found = 1;
    end
    chk("reach_idx300", 32'(found), 1);
    img_ready = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("abort_pulse", 32'(abort), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_rearm", 32'(rearm), 0);
    chk("abort_spike_cnt", 32'(spike_cnt), 150);
    chk("abort_state", 32'(dbg_state), 32'(IDLE));
    tick();
    chk("abort_one_cycle", 32'(abort), 0);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (done || rearm || busy) bad++;
    end
    chk("abort_quiet", 32'(bad), 0);
    chk("abort_spike_hold", 32'(spike_cnt), 150);
    fill(8'h81);
    img_ready = 1'b1;
    run_scan(-1, 196);

    // Synchronous reset at index 500.
    img_ready = 1'b0;
    tick(); tick();
    fill(8'hFF);
    img_ready = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 3000 && found == 0; cyc++) begin
      tick();
      if (out_valid && out_idx == 10'd500) found = 1;
    end
    chk("reach_idx500", 32'(found), 1);
    rst = 1'b1;
    tick();
    chk_reset_vals();
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done || rearm || busy || out_valid) bad++;
    end
    chk("no_start_after_rst", 32'(bad), 0);
    img_ready = 1'b0;
    tick(); tick();
    fill(8'hFF);
    img_ready = 1'b1;
    run_scan(-1, 784);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
